// File: rtl/dff_piso_unld.sv
// Parallel-in serial-out unloader: captures a WIDTH-bit word and streams it out
// one bit per accepted handshake, with a zero-bubble reload path on the last bit.
module dff_piso_unld #(
  parameter int WIDTH     = 32,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_en,
  input  logic [WIDTH-1:0] data_i,
  output logic             load_ready,
  output logic             ser_o,
  output logic             ser_valid_o,
  input  logic             ser_ready_i,
  output logic             busy_o,
  output logic             done_o
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_shreg;
  logic [CW-1:0]    r_cnt;
  logic             r_done;

  logic             w_in_shift;
  logic             w_last;
  logic             w_load_acc;
  logic             w_bit_acc;
  logic             w_last_acc;
  logic [WIDTH-1:0] w_shifted;

  // Shift direction moves the next bit toward whichever end drives ser_o.
  assign w_shifted = MSB_FIRST ? {r_shreg[WIDTH-2:0], 1'b0}
                               : {1'b0, r_shreg[WIDTH-1:1]};

  always_comb begin
    w_state_nxt = r_state;
    w_in_shift  = (r_state == SHIFT);
    w_last      = (r_cnt == CNT_ONE);
    load_ready  = 1'b1;
    ser_valid_o = 1'b0;
    busy_o      = 1'b0;
    ser_o       = 1'b0;
    w_bit_acc   = 1'b0;
    w_last_acc  = 1'b0;
    w_load_acc  = 1'b0;

    case (r_state)
      IDLE: begin
        w_load_acc = load_en;
        if (w_load_acc) w_state_nxt = SHIFT;
      end
      SHIFT: begin
        // Accepting a new word is only safe once the final bit leaves this cycle.
        load_ready  = w_last && ser_ready_i;
        ser_valid_o = 1'b1;
        busy_o      = 1'b1;
        ser_o       = MSB_FIRST ? r_shreg[WIDTH-1] : r_shreg[0];
        w_bit_acc   = ser_ready_i;
        w_last_acc  = w_bit_acc && w_last;
        w_load_acc  = load_en && load_ready;
        if (w_last_acc && !w_load_acc) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_shreg <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_last_acc;
      if (w_load_acc) begin
        r_shreg <= data_i;
        r_cnt   <= CNT_FULL;
      end else if (w_bit_acc) begin
        r_shreg <= w_shifted;
        r_cnt   <= r_cnt - CNT_ONE;
      end
    end
  end

  assign done_o = r_done;

endmodule
